pipe_stall_ctrl: RTL and testbench

// Central stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stall_ctrl_pkg.sv | 14 +
 rtl/pipe_stall_ctrl_load_use_detect.sv | 10 +
 rtl/pipe_stall_ctrl.sv | 88 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: sequencer state encoding and shared pipeline constants
package pipe_stall_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESUME    = 2'd3
  } state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic BUBBLE_CTRL = 1'b0;
  function automatic logic cache_miss(input logic access, input logic hit);
    return access & ~hit;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// pipe_stall_ctrl_load_use_detect: flags a load in EX whose result is read by the instruction in ID
module pipe_stall_ctrl_load_use_detect (
  input  logic       memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hz
);
  assign hz = memread & (ex_rt != 5'd0) & ((ex_rt == rs) | (ex_rt == rt));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/flush sequencer with dcache miss writeback/refill handshake
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_ex_memread_i,
  input  logic [4:0]             id_ex_rt_i,
  input  logic [4:0]             if_id_rs_i,
  input  logic [4:0]             if_id_rt_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_access_i,
  input  logic                   cache_hit_i,
  input  logic                   cache_dirty_i,
  input  logic                   mem_ack_i,
  output logic                   pc_write_o,
  output logic                   if_id_stall_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_bubble_o,
  output logic                   ex_mem_stall_o,
  output logic                   mem_wb_stall_o,
  output logic                   mem_req_o,
  output logic                   mem_write_o,
  output logic                   cache_refill_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   err_timeout_o
);
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic run, miss, hz, hz_run, freeze, mem_wait;
  pipe_stall_ctrl_load_use_detect u_lud (
    .memread (id_ex_memread_i),
    .ex_rt   (id_ex_rt_i),
    .rs      (if_id_rs_i),
    .rt      (if_id_rt_i),
    .hz      (hz)
  );
  assign run      = (state == RUN);
  assign miss     = run & cache_miss(mem_access_i, cache_hit_i);
  assign freeze   = ~run | miss;
  assign hz_run   = hz & run & ~miss;
  assign mem_wait = mem_req_o & ~mem_ack_i;
  always_comb begin
    state_nx       = state;
    pc_write_o     = 1'b1;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_stall_o = 1'b0;
    mem_req_o      = 1'b0;
    mem_write_o    = 1'b0;
    cache_refill_o = 1'b0;
    state_nx = run ? (miss ? (cache_dirty_i ? WRITEBACK : REFILL) : RUN)
             : (state == WRITEBACK) ? (mem_ack_i ? REFILL : WRITEBACK)
             : (state == REFILL) ? (mem_ack_i ? RESUME : REFILL)
             : RUN;
    pc_write_o     = ~(freeze | hz_run);
    if_id_stall_o  = freeze | hz_run;
    id_ex_bubble_o = hz_run;
    if_id_flush_o  = branch_taken_i & ~hz_run & ~freeze;
    ex_mem_stall_o = freeze;
    mem_wb_stall_o = freeze;
    mem_req_o      = (state == WRITEBACK) | (state == REFILL);
    mem_write_o    = (state == WRITEBACK);
    cache_refill_o = (state == RESUME);
  end
  // wait counter holds at its limit so the timeout compare cannot wrap past it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      stall_cnt_o   <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= (state_nx != state) ? '0
                     : (mem_wait && wait_cnt != WAIT_MAX) ? wait_cnt + WW'(1) : wait_cnt;
      err_timeout_o <= err_timeout_o | (mem_wait & (wait_cnt == WAIT_MAX));
      stall_cnt_o   <= ((freeze | hz_run) && !(&stall_cnt_o)) ? stall_cnt_o + STALL_CNT_W'(1) : stall_cnt_o;
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: vector table plus scoreboarded sequences for stall, flush, miss and timeout behaviour
module tb_pipe_stall_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       id_ex_memread_i = 1'b0;
  logic [4:0] id_ex_rt_i = '0, if_id_rs_i = '0, if_id_rt_i = '0;
  logic       branch_taken_i = 1'b0, mem_access_i = 1'b0, cache_hit_i = 1'b0;
  logic       cache_dirty_i = 1'b0, mem_ack_i = 1'b0;
  logic       pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o;
  logic       ex_mem_stall_o, mem_wb_stall_o, mem_req_o, mem_write_o, cache_refill_o;
  logic [2:0] stall_cnt_o;
  logic       err_timeout_o;
  logic [8:0] outs;
  int passed = 0, total = 0;

  pipe_stall_ctrl #(.MEM_TIMEOUT(8), .STALL_CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
    .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
    .branch_taken_i(branch_taken_i), .mem_access_i(mem_access_i),
    .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .ex_mem_stall_o(ex_mem_stall_o),
    .mem_wb_stall_o(mem_wb_stall_o), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .cache_refill_o(cache_refill_o), .stall_cnt_o(stall_cnt_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;
  assign outs = {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
                 ex_mem_stall_o, mem_wb_stall_o, mem_req_o, mem_write_o, cache_refill_o};

  // {pc_write, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_stall, mem_req, mem_write, cache_refill}
  localparam logic [8:0] O_RUN = 9'b100000000;
  localparam logic [8:0] O_HZ  = 9'b010100000;
  localparam logic [8:0] O_FL  = 9'b101000000;
  localparam logic [8:0] O_FZ  = 9'b010011000;
  localparam logic [8:0] O_WB  = 9'b010011110;
  localparam logic [8:0] O_RF  = 9'b010011100;
  localparam logic [8:0] O_RS  = 9'b010011001;

  typedef struct {
    logic       memread;
    logic [4:0] ex_rt, rs, rt;
    logic       br, acc, hit, dirty, ack;
    logic [8:0] outs;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t q[$];
  vec_t tbl[9];

  function automatic vec_t mk(input logic memread, input logic [4:0] ex_rt, input logic [4:0] rs,
                              input logic [4:0] rt, input logic br, input logic acc, input logic hit,
                              input logic dirty, input logic ack, input logic [8:0] o,
                              input logic [2:0] cnt, input logic err);
    vec_t v;
    v.memread = memread; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt;
    v.br = br; v.acc = acc; v.hit = hit; v.dirty = dirty; v.ack = ack;
    v.outs = o; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  function automatic logic [2:0] sat(input int n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic drive(input vec_t v);
    id_ex_memread_i = v.memread; id_ex_rt_i = v.ex_rt; if_id_rs_i = v.rs; if_id_rt_i = v.rt;
    branch_taken_i = v.br; mem_access_i = v.acc; cache_hit_i = v.hit;
    cache_dirty_i = v.dirty; mem_ack_i = v.ack;
  endtask

  task automatic cyc(input string tag, input vec_t v);
    vec_t e;
    drive(v);
    q.push_back(v);
    @(negedge clk_i);
    e = q.pop_front();
    chk({tag, " outs"}, 32'(outs), 32'(e.outs));
    chk({tag, " stall_cnt"}, 32'(stall_cnt_o), 32'(e.cnt));
    chk({tag, " err"}, 32'(err_timeout_o), 32'(e.err));
    @(posedge clk_i);
    #1;
  endtask

  task automatic rst_dut();
    rst_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0);
    tbl[1] = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, O_HZ,  0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1, 0);
    tbl[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1, 0);
    tbl[4] = mk(1, 7, 2, 7, 0, 0, 0, 0, 0, O_HZ,  1, 0);
    tbl[5] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_FL,  2, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2, 0);
    tbl[7] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, O_HZ,  2, 0);
    tbl[8] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, O_RUN, 3, 0);

    #2;
    chk("reset outs", 32'(outs), 32'(O_RUN));
    chk("reset stall_cnt", 32'(stall_cnt_o), 0);
    chk("reset err", 32'(err_timeout_o), 0);
    rst_dut();
    for (int i = 0; i < 9; i++) cyc($sformatf("tbl%0d", i), tbl[i]);

    // clean miss: ack raised while no request is pending must be ignored
    rst_dut();
    cyc("clean miss", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, O_FZ, 0, 0));
    for (int k = 1; k <= 5; k++)
      cyc($sformatf("clean refill%0d", k), mk(0, 0, 0, 0, 0, 1, 0, 0, k == 5, O_RF, 3'(k), 0));
    cyc("clean resume", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, O_RS, 6, 0));
    cyc("clean hit", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, O_RUN, 7, 0));

    // dirty miss with a taken branch held throughout
    rst_dut();
    cyc("dirty miss", mk(0, 0, 0, 0, 1, 1, 0, 1, 0, O_FZ, 0, 0));
    for (int k = 1; k <= 4; k++)
      cyc($sformatf("dirty wb%0d", k), mk(0, 0, 0, 0, 1, 1, 0, 1, k == 4, O_WB, 3'(k), 0));
    for (int k = 1; k <= 3; k++)
      cyc($sformatf("dirty refill%0d", k), mk(0, 0, 0, 0, 1, 1, 0, 1, k == 3, O_RF, sat(4 + k), 0));
    cyc("dirty resume", mk(0, 0, 0, 0, 1, 1, 0, 1, 0, O_RS, 7, 0));
    cyc("dirty hit flush", mk(0, 0, 0, 0, 1, 1, 1, 0, 0, O_FL, 7, 0));

    // timeout: sets after eight waiting refill cycles and stays set
    rst_dut();
    cyc("to miss", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_FZ, 0, 0));
    for (int k = 1; k <= 11; k++)
      cyc($sformatf("to refill%0d", k), mk(0, 0, 0, 0, 0, 1, 0, 0, k == 11, O_RF, sat(k), k >= 9));
    cyc("to resume", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_RS, 7, 1));
    cyc("to run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 7, 1));
    cyc("re miss", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_FZ, 7, 1));
    for (int k = 1; k <= 2; k++)
      cyc($sformatf("re refill%0d", k), mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_RF, 7, 1));

    // asynchronous reset in the middle of a refill
    rst_i = 1'b0;
    #1;
    chk("async rst mem_req", 32'(mem_req_o), 0);
    chk("async rst mem_write", 32'(mem_write_o), 0);
    chk("async rst refill", 32'(cache_refill_o), 0);
    chk("async rst stall_cnt", 32'(stall_cnt_o), 0);
    chk("async rst err", 32'(err_timeout_o), 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0));
    #1;
    chk("async rst outs", 32'(outs), 32'(O_RUN));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc("post rst idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN, 0, 0));

    // nine load-use stalls saturate the 3-bit counter
    for (int k = 0; k < 9; k++)
      cyc($sformatf("sat hz%0d", k), mk(1, 4, 0, 4, 0, 0, 0, 0, 0, O_HZ, sat(k), 0));
    cyc("sat final", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 7, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
